// File: rtl/line_clear_ctrl_pkg.sv
// Shared Tetris definitions: board geometry, CLEAR-phase state encoding and line score lookup.
// The score lookup is only consumed when the design is built with LINE_SCORE_EN defined.
package tetris_pkg;

  localparam int ROWS    = 11;
  localparam int COLS    = 8;
  localparam int ROW_AW  = 4;
  localparam int SCORE_W = 16;

  typedef enum logic [2:0] {
    CLR_IDLE     = 3'd0,
    CLR_SCAN_RD  = 3'd1,
    CLR_SCAN_CHK = 3'd2,
    CLR_SH_RD    = 3'd3,
    CLR_SH_WR    = 3'd4,
    CLR_SH_TOP   = 3'd5,
    CLR_FINISH   = 3'd6
  } clr_state_e;

  localparam logic [SCORE_W-1:0] SCORE_0  = 16'd0;
  localparam logic [SCORE_W-1:0] SCORE_1  = 16'd1;
  localparam logic [SCORE_W-1:0] SCORE_2  = 16'd3;
  localparam logic [SCORE_W-1:0] SCORE_3  = 16'd5;
  localparam logic [SCORE_W-1:0] SCORE_4P = 16'd8;

  // Four or more lines in one pass all earn the top award.
  function automatic logic [SCORE_W-1:0] line_score(input logic [ROW_AW-1:0] n);
    logic [SCORE_W-1:0] pts;
    case (n)
      ROW_AW'(0): pts = SCORE_0;
      ROW_AW'(1): pts = SCORE_1;
      ROW_AW'(2): pts = SCORE_2;
      ROW_AW'(3): pts = SCORE_3;
      default:    pts = SCORE_4P;
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/line_clear_ctrl_if.sv
// Handshake with the main FSM plus the board RAM port owned by the line-clear controller.
// master = main FSM / board RAM side, slave = line_clear_ctrl.
interface line_clear_if;
  import tetris_pkg::*;

  logic              start_clear;
  logic [ROW_AW-1:0] row_rd_addr;
  logic [COLS-1:0]   row_rd_data;
  logic              row_wr_en;
  logic [ROW_AW-1:0] row_wr_addr;
  logic [COLS-1:0]   row_wr_data;
  logic              busy;
  logic              done;
  logic [ROW_AW-1:0] lines_cleared;

  modport master (
    output start_clear,
    output row_rd_data,
    input  row_rd_addr,
    input  row_wr_en,
    input  row_wr_addr,
    input  row_wr_data,
    input  busy,
    input  done,
    input  lines_cleared
  );

  modport slave (
    input  start_clear,
    input  row_rd_data,
    output row_rd_addr,
    output row_wr_en,
    output row_wr_addr,
    output row_wr_data,
    output busy,
    output done,
    output lines_cleared
  );

endinterface

// File: rtl/line_clear_ctrl_score.sv
// line_score_acc: saturating score accumulator fed with the line count of each finished pass.
// Only present in builds with LINE_SCORE_EN defined.
`ifdef LINE_SCORE_EN
module line_score_acc
  import tetris_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               add_en_i,
  input  logic [ROW_AW-1:0]  count_i,
  output logic [SCORE_W-1:0] score_o
);

  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W:0]   sum_d;

  assign sum_d = {1'b0, score_q} + {1'b0, line_score(count_i)};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      score_q <= '0;
    end else if (add_en_i) begin
      score_q <= sum_d[SCORE_W] ? {SCORE_W{1'b1}} : sum_d[SCORE_W-1:0];
    end
  end

  assign score_o = score_q;

endmodule
`endif

// File: rtl/line_clear_ctrl.sv
// CLEAR phase of the game loop: scans the board bottom-up, removes full rows by shifting down.
// Optional LINE_SCORE_EN adds a saturating 16-bit score output.
module line_clear_ctrl
  import tetris_pkg::*;
(
  input  logic clka,
  input  logic restart,
  line_clear_if.slave bus
`ifdef LINE_SCORE_EN
  ,
  output logic [SCORE_W-1:0] score
`endif
);

  clr_state_e        state_q;
  logic [ROW_AW-1:0] r_q;
  logic [ROW_AW-1:0] d_q;
  logic [ROW_AW-1:0] count_q;
  logic              busy_q;
  logic              done_q;
  logic              wr_en_q;
  logic [ROW_AW-1:0] lines_q;
  logic [ROW_AW-1:0] rd_addr_q;
  logic [ROW_AW-1:0] wr_addr_q;
  logic [COLS-1:0]   wr_data_q;
  logic              row_full;

  assign row_full = &bus.row_rd_data;

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      state_q   <= CLR_IDLE;
      r_q       <= '0;
      d_q       <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      lines_q   <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        CLR_IDLE: begin
          if (bus.start_clear) begin
            r_q       <= ROW_AW'(ROWS - 1);
            rd_addr_q <= ROW_AW'(ROWS - 1);
            count_q   <= '0;
            busy_q    <= 1'b1;
            state_q   <= CLR_SCAN_RD;
          end
        end
        CLR_SCAN_RD: begin
          state_q <= CLR_SCAN_CHK;
        end
        CLR_SCAN_CHK: begin
          if (row_full && (r_q == '0)) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            state_q   <= CLR_SH_TOP;
          end else if (row_full) begin
            d_q       <= r_q;
            rd_addr_q <= r_q - ROW_AW'(1);
            state_q   <= CLR_SH_RD;
          end else if (r_q == '0) begin
            done_q  <= 1'b1;
            lines_q <= count_q;
            state_q <= CLR_FINISH;
          end else begin
            r_q       <= r_q - ROW_AW'(1);
            rd_addr_q <= r_q - ROW_AW'(1);
            state_q   <= CLR_SCAN_RD;
          end
        end
        CLR_SH_RD: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= d_q;
          state_q   <= CLR_SH_WR;
        end
        CLR_SH_WR: begin
          if (d_q == ROW_AW'(1)) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            state_q   <= CLR_SH_TOP;
          end else begin
            wr_data_q <= bus.row_rd_data;
            d_q       <= d_q - ROW_AW'(1);
            rd_addr_q <= d_q - ROW_AW'(2);
            state_q   <= CLR_SH_RD;
          end
        end
        CLR_SH_TOP: begin
          // Rescan the same row: the row above has just dropped into it.
          count_q   <= count_q + ROW_AW'(1);
          rd_addr_q <= r_q;
          state_q   <= CLR_SCAN_RD;
        end
        CLR_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= CLR_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= CLR_IDLE;
        end
      endcase
    end
  end

  assign bus.row_rd_addr   = rd_addr_q;
  assign bus.row_wr_en     = wr_en_q;
  assign bus.row_wr_addr   = wr_addr_q;
  // The shifted row arrives from the synchronous RAM during SH_WR itself, so it is
  // forwarded straight to the write port; wr_data_q keeps the value between writes.
  assign bus.row_wr_data   = (state_q == CLR_SH_WR) ? bus.row_rd_data : wr_data_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.lines_cleared = lines_q;

`ifdef LINE_SCORE_EN
  line_score_acc u_score (
    .clk_i    (clka),
    .rst_i    (restart),
    .add_en_i (done_q),
    .count_i  (lines_q),
    .score_o  (score)
  );
`endif

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Scoreboard bench for line_clear_ctrl: a filter-based board model predicts each pass,
// a monitor checks lines, timing, write count and final board whenever done pulses.
module tb_line_clear_ctrl;
  import tetris_pkg::*;

  typedef logic [ROWS*COLS-1:0] board_t;
  typedef struct {
    int     lines;
    int     t_done;
    int     writes;
    board_t board;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_clear_if bus ();
`ifdef LINE_SCORE_EN
  logic [SCORE_W-1:0] score;
`endif

  line_clear_ctrl dut (
    .clka    (clk),
    .restart (rst),
    .bus     (bus)
`ifdef LINE_SCORE_EN
    ,
    .score   (score)
`endif
  );

  logic [COLS-1:0] mem [ROWS];
  logic   ld_req   = 1'b0;
  board_t ld_board = '0;

  always @(posedge clk) begin
    if (ld_req) begin
      for (int i = 0; i < ROWS; i++) mem[i] <= ld_board[i*COLS +: COLS];
    end else if (bus.row_wr_en && int'(bus.row_wr_addr) < ROWS) begin
      mem[int'(bus.row_wr_addr)] <= bus.row_wr_data;
    end
    bus.row_rd_data <= (int'(bus.row_rd_addr) < ROWS) ? mem[int'(bus.row_rd_addr)] : '0;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int dones  = 0;
  int pushes = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Full rows are dropped and the rest fall to the bottom; a full row originally at i
  // is found at i plus the number of full rows beneath it, costing 2*pos+3 cycles.
  function automatic exp_t model(input board_t b, input int t_start);
    exp_t e;
    int k   = 0;
    int wr  = 0;
    int lat = 2 * ROWS;
    int pos = ROWS - 1;
    board_t fb = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      logic [COLS-1:0] row;
      row = b[i*COLS +: COLS];
      if (&row) begin
        lat += 2 * (i + k) + 3;
        wr  += i + k + 1;
        k++;
      end else begin
        fb[pos*COLS +: COLS] = row;
        pos--;
      end
    end
    e.lines  = k;
    e.t_done = t_start + lat;
    e.writes = wr;
    e.board  = fb;
    return e;
  endfunction

  initial begin
    int wcount = 0;
    int stray  = 0;
    exp_t e;
    board_t got;
    forever begin
      @(negedge clk);
      if (rst) begin
        wcount = 0;
        stray  = 0;
      end else begin
        if (bus.row_wr_en) begin
          wcount++;
          if (!bus.busy) stray++;
        end
        if (bus.done) begin
          dones++;
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < ROWS; i++) got[i*COLS +: COLS] = mem[i];
            check("lines_cleared", bus.lines_cleared, e.lines);
            check("done_cycle", cyc, e.t_done);
            check("write_count", wcount, e.writes);
            check("final_board", got, e.board);
            check("writes_while_idle", stray, 0);
          end
          wcount = 0;
          stray  = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL pass_timeout: got busy=%0b pending=%0d expected idle", bus.busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic start_pass(input board_t b);
    @(negedge clk);
    ld_board = b;
    ld_req   = 1'b1;
    @(negedge clk);
    ld_req = 1'b0;
    bus.start_clear = 1'b1;
    exp_q.push_back(model(b, cyc + 1));
    pushes++;
    @(negedge clk);
    bus.start_clear = 1'b0;
  endtask

  task automatic run_pass(input board_t b, input bit extra_start);
    start_pass(b);
    if (extra_start) begin
      repeat (5) @(negedge clk);
      bus.start_clear = 1'b1;
      @(negedge clk);
      bus.start_clear = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    board_t b;
    int n;
    bus.start_clear = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_wr_en", bus.row_wr_en, 0);
    check("rst_lines", bus.lines_cleared, 0);
    check("rst_rd_addr", bus.row_rd_addr, 0);
    check("rst_wr_addr", bus.row_wr_addr, 0);
    check("rst_wr_data", bus.row_wr_data, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

`ifdef LINE_SCORE_EN
    b = '0;
    b[10*COLS +: COLS] = 8'hFF;
    run_pass(b, 1'b0);
    b = '0;
    for (int i = 7; i <= 10; i++) b[i*COLS +: COLS] = 8'hFF;
    run_pass(b, 1'b0);
    check("score_1_then_4", score, 9);
`endif

    // empty board, with a second start pulsed mid-pass
    run_pass('0, 1'b1);
    repeat (40) @(negedge clk);
    check("single_done_pulse", dones, pushes);

    b = '0;
    b[10*COLS +: COLS] = 8'hFF;
    b[9*COLS +: COLS]  = 8'h81;
    run_pass(b, 1'b0);

    b = '0;
    b[10*COLS +: COLS] = 8'hFF;
    b[9*COLS +: COLS]  = 8'hFF;
    b[8*COLS +: COLS]  = 8'h3C;
    run_pass(b, 1'b0);

    b = '0;
    b[0 +: COLS] = 8'hFF;
    run_pass(b, 1'b0);
    run_pass('0, 1'b0);

    run_pass('1, 1'b0);

    // reset in the middle of the first shift write
    b = '0;
    b[10*COLS +: COLS] = 8'hFF;
    start_pass(b);
    n = 0;
    while (!(bus.row_wr_en && bus.row_wr_addr == ROW_AW'(10)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached_sh_wr", n < 200, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_wr_en", bus.row_wr_en, 0);
    check("mid_rst_lines", bus.lines_cleared, 0);
    check("mid_rst_wr_addr", bus.row_wr_addr, 0);
    exp_q.delete();
    pushes--;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int p = 0; p < 25; p++) begin
      for (int i = 0; i < ROWS; i++) begin
        b[i*COLS +: COLS] = ($urandom_range(0, 2) == 0) ? 8'hFF : COLS'($urandom);
      end
      run_pass(b, ($urandom_range(0, 3) == 0));
    end

    repeat (40) @(negedge clk);
    check("all_passes_done", dones, pushes);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
